gpr_file_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the next-generation MIPS datapath, serving the decode stage.
- Generalises the 2-read/1-write GPR to NUM_RD registered read ports and NUM_WR write ports.
- Adds a per-port read-enable hold for pipeline stalls, deterministic write-port priority and a registered write-collision flag.
- Write-to-read bypass is optional.

---
 rtl/gpr_pkg.sv | 30 +++
 rtl/gpr_file_mp_if.sv | 30 +++
 rtl/gpr_rd_port.sv | 65 ++++++
 rtl/gpr_file_mp.sv | 113 +++++++++++
 tb/tb_gpr_file_mp.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/gpr_pkg.sv
// Shared constants and the write-port arbitration used by both the storage
// array and the read-port bypass in gpr_file_mp.
package gpr_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;
  localparam int MAX_WR     = 4;
  localparam int WIN_IDX_W  = $clog2(MAX_WR);

  typedef struct packed {
    logic                 valid;
    logic [WIN_IDX_W-1:0] idx;
  } wr_win_t;

  // hit[j] = port j is live and targets the address of interest; the
  // highest-indexed hit wins so storage and bypass always agree.
  function automatic wr_win_t resolve_wr(input logic [MAX_WR-1:0] hit);
    wr_win_t win;
    win = '0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (hit[j]) begin
        win.valid = 1'b1;
        win.idx   = WIN_IDX_W'(j);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/gpr_file_mp_if.sv
// Read/write bus of the multi-port GPR file; master drives addresses and
// write data, slave (the register file) returns read data and the conflict flag.
interface gpr_file_mp_if
  import gpr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     wr_conflict;

  modport master (
    output rd_addr, rd_en, wr_en, wr_addr, wr_data,
    input  rd_data, wr_conflict
  );

  modport slave (
    input  rd_addr, rd_en, wr_en, wr_addr, wr_data,
    output rd_data, wr_conflict
  );

endinterface

// File: rtl/gpr_rd_port.sv
// One registered read port: address mux over the storage image, optional
// write-first bypass (GPR_BYPASS_EN) and an rd_en hold register.
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
`ifdef GPR_BYPASS_EN
  parameter int NUM_WR   = 1,
`endif
  parameter int ZERO_REG = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rd_en,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [(2**ADDR_W)*DATA_W-1:0]    regs_flat,
`ifdef GPR_BYPASS_EN
  input  logic [NUM_WR-1:0]                wr_live,
  input  logic [NUM_WR*ADDR_W-1:0]         wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]         wr_data,
`endif
  output logic [DATA_W-1:0]                rd_data
);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] rd_val;

`ifdef GPR_BYPASS_EN
  logic [MAX_WR-1:0]        hit;
  wr_win_t                  win;
  logic [MAX_WR*DATA_W-1:0] wr_data_ext;

  assign wr_data_ext = (MAX_WR*DATA_W)'(wr_data);
`endif

  always_comb begin
    rd_val = regs_flat[int'(rd_addr)*DATA_W +: DATA_W];
`ifdef GPR_BYPASS_EN
    hit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      hit[j] = wr_live[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr);
    end
    win = resolve_wr(hit);
    if (win.valid) begin
      rd_val = wr_data_ext[int'(win.idx)*DATA_W +: DATA_W];
    end
`endif
    if (ZERO_REG != 0 && rd_addr == ADDR_W'(ZERO_ADDR)) begin
      rd_val = '0;
    end
    rd_data_d = rd_en ? rd_val : rd_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: NUM_RD registered read ports, NUM_WR prioritised write ports.
// Define GPR_BYPASS_EN for write-first reads; default is read-before-write.
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  gpr_file_mp_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DATA_W-1:0]        regs_d [DEPTH];
  logic [DEPTH*DATA_W-1:0]  regs_flat;
  logic                     wr_conflict_q, wr_conflict_d;
  logic [NUM_WR-1:0]        wr_live;
  logic [MAX_WR*DATA_W-1:0] wr_data_ext;
  logic [DATA_W-1:0]        rd_data_k [NUM_RD];

  assign wr_data_ext = (MAX_WR*DATA_W)'(bus.wr_data);

  // A write to the hard-wired zero register is dropped before arbitration,
  // so it neither lands in storage, bypasses, nor counts as a collision.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_live[j] = bus.wr_en[j] &&
                   !(ZERO_REG != 0 && bus.wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_ADDR));
    end
  end

  always_comb begin
    logic [MAX_WR-1:0] hit;
    wr_win_t           win;
    for (int a = 0; a < DEPTH; a++) begin
      hit = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        hit[j] = wr_live[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(a));
      end
      win = resolve_wr(hit);
      regs_d[a] = win.valid ? wr_data_ext[int'(win.idx)*DATA_W +: DATA_W] : regs_q[a];
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_live[i] && wr_live[j] &&
            bus.wr_addr[i*ADDR_W +: ADDR_W] == bus.wr_addr[j*ADDR_W +: ADDR_W]) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        regs_q[a] <= '0;
      end
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      regs_flat[a*DATA_W +: DATA_W] = regs_q[a];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    gpr_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
`ifdef GPR_BYPASS_EN
      .NUM_WR   (NUM_WR),
`endif
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (bus.rd_en[k]),
      .rd_addr   (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .regs_flat (regs_flat),
`ifdef GPR_BYPASS_EN
      .wr_live   (wr_live),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
`endif
      .rd_data   (rd_data_k[k])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = rd_data_k[k];
    end
  end

  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_gpr_file_mp.sv
// Scoreboard bench for gpr_file_mp: 2R/2W instance with zero register, plus a
// 1R/1W instance with ZERO_REG=0. Expectations follow GPR_BYPASS_EN.
module tb_gpr_file_mp;

`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gpr_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();
  gpr_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .NUM_WR(1)) zb ();

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0)) dut_z0 (
    .clk   (clk),
    .reset (reset),
    .bus   (zb.slave)
  );

  typedef struct packed {
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        conf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [32];
  logic [31:0] exp_rd [2];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 32; a++) mem[a] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // Drive one cycle on the 2R/2W instance, push the expected outcome, then
  // pop and compare once the edge has produced it.
  task automatic cyc(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                     input logic [31:0] wd0, input logic [31:0] wd1);
    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [1:0]  live;
    logic [31:0] v;
    exp_t        e;
    ra[0] = ra0; ra[1] = ra1;
    wa[0] = wa0; wa[1] = wa1;
    wd[0] = wd0; wd[1] = wd1;
    bus.rd_en   = re;
    bus.rd_addr = {ra1, ra0};
    bus.wr_en   = we;
    bus.wr_addr = {wa1, wa0};
    bus.wr_data = {wd1, wd0};
    for (int j = 0; j < 2; j++) live[j] = we[j] && (wa[j] != 5'd0);
    for (int k = 0; k < 2; k++) begin
      if (re[k]) begin
        v = mem[ra[k]];
        if (BYP) begin
          for (int j = 0; j < 2; j++) if (live[j] && wa[j] == ra[k]) v = wd[j];
        end
        if (ra[k] == 5'd0) v = '0;
        exp_rd[k] = v;
      end
    end
    e.rd0  = exp_rd[0];
    e.rd1  = exp_rd[1];
    e.conf = live[0] && live[1] && (wa[0] == wa[1]);
    sb.push_back(e);
    for (int j = 0; j < 2; j++) if (live[j]) mem[wa[j]] = wd[j];
    @(posedge clk);
    #1;
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rd0", bus.rd_data[31:0], e.rd0);
      chk("rd1", bus.rd_data[63:32], e.rd1);
      chk("wr_conflict", 32'(bus.wr_conflict), 32'(e.conf));
    end
  endtask

  task automatic idle();
    cyc(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    bus.rd_en = '0; bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    zb.rd_en = '0;  zb.rd_addr = '0;  zb.wr_en = '0;  zb.wr_addr = '0;  zb.wr_data = '0;
    model_clear();

    #12;
    chk("reset_rd", bus.rd_data[31:0] | bus.rd_data[63:32], 32'h0);
    chk("reset_conf", 32'(bus.wr_conflict), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Collision on r5 (port1 wins DEADBEEF), then read r5 while colliding on r6.
    cyc(2'b00, 5'd0, 5'd0, 2'b11, 5'd5, 5'd5, 32'h1111_1111, 32'hDEAD_BEEF);
    cyc(2'b11, 5'd5, 5'd5, 2'b11, 5'd6, 5'd6, 32'h6, 32'h66);
    // Mid-cycle reset with a write to r8 pending.
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd8}; bus.wr_data = {32'h0, 32'h8888_8888};
    #3;
    reset = 1'b1;
    #1;
    chk("midreset_rd0", bus.rd_data[31:0], 32'h0);
    chk("midreset_rd1", bus.rd_data[63:32], 32'h0);
    chk("midreset_conf", 32'(bus.wr_conflict), 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    bus.wr_en = '0;
    reset = 1'b0;
    cyc(2'b11, 5'd5, 5'd8, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    // Basic write then dual read of r3.
    cyc(2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 5'd0, 32'h1234_5678, 32'h0);
    cyc(2'b11, 5'd3, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    // Both ports write r0: dropped, no conflict; r0 reads 0.
    cyc(2'b00, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(2'b11, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Collision on r7: flag for exactly one cycle, port1 data stored.
    cyc(2'b00, 5'd0, 5'd0, 2'b11, 5'd7, 5'd7, 32'hAAAA_0000, 32'h5555_FFFF);
    cyc(2'b01, 5'd7, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    idle();

    // Same-cycle read/write on r9.
    cyc(2'b00, 5'd0, 5'd0, 2'b01, 5'd9, 5'd0, 32'h1, 32'h0);
    cyc(2'b01, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 32'h0, 32'h2);
    cyc(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    // Stall hold on port 0 while r4 is rewritten.
    cyc(2'b00, 5'd0, 5'd0, 2'b01, 5'd4, 5'd0, 32'h44, 32'h0);
    cyc(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    cyc(2'b10, 5'd4, 5'd4, 2'b01, 5'd4, 5'd0, 32'h99, 32'h0);
    cyc(2'b00, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    cyc(2'b00, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    cyc(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    // Random traffic on a narrow address window to provoke collisions and hits.
    for (int n = 0; n < 300; n++) begin
      cyc(2'($urandom_range(3)), 5'($urandom_range(7)), 5'($urandom_range(7)),
          2'($urandom_range(3)), 5'($urandom_range(7)), 5'($urandom_range(7)),
          $urandom, $urandom);
    end

    // ZERO_REG=0 instance: r0 is ordinary storage.
    zb.wr_en = 1'b1; zb.wr_addr = 5'd0; zb.wr_data = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    zb.wr_en = 1'b0; zb.rd_en = 1'b1; zb.rd_addr = 5'd0;
    @(posedge clk);
    #1;
    chk("z0_r0", zb.rd_data, 32'hFFFF_FFFF);
    chk("z0_conf", 32'(zb.wr_conflict), 32'h0);
    zb.rd_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
